// File: rtl/apu_pkg.sv
// ============================================================================
// Module   : apu_pkg
// Purpose  : Shared constants and types for the APU register writer: the
//            highest legal register offset, the status register offset,
//            channel indices and the byte-parser state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apu_pkg;

    // Highest register offset ($4017) the parser accepts as an address byte
    localparam logic [7:0] ADDR_MAX    = 8'h17;
    // Offset of the channel enable / status register ($4015)
    localparam logic [4:0] ADDR_STATUS = 5'h15;

    // Channel indices into reg_change / channel_enable
    localparam int CH_SQ1   = 0;
    localparam int CH_SQ2   = 1;
    localparam int CH_TRI   = 2;
    localparam int CH_NOISE = 3;
    localparam int NUM_CH   = 4;

    typedef enum logic {ST_ADDR, ST_DATA} parse_state_t;

endpackage

`default_nettype wire

// File: rtl/apu_cmd_timeout.sv
// ============================================================================
// Module   : apu_cmd_timeout
// Purpose  : Saturating idle counter used while the parser waits for a data
//            byte. o_expired is high while the count sits at
//            TIMEOUT_CYCLES-1.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_clear         - restart the count at zero
//            i_count         - advance the count by one (saturating)
//            o_expired       - count has reached TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apu_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_count && (r_timer != {TW{1'b1}})) begin
            // Saturate instead of wrapping so a stale count never re-arms
            r_timer <= r_timer + 1'b1;
        end
    end

    assign o_expired = (r_timer == LAST);

endmodule

`default_nettype wire

// File: rtl/apu_register_writer.sv
// ============================================================================
// Module   : apu_register_writer
// Purpose  : Byte-stream command decoder for the APU register bank. Pairs an
//            address byte with the following data byte, updates the shadow
//            registers $4000-$400F and $4015, and flips a per-channel toggle
//            whenever a channel must reload its parameters.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            rx_data/rx_valid - received byte and its 1-cycle strobe
//            reg_bank         - shadow regs, byte n = $4000+n (n = 0..15)
//            channel_enable   - $4015[4:0]
//            reg_change       - reload toggles [0] sq1 [1] sq2 [2] tri [3] noise
//            write_strobe     - 1-cycle pulse on every accepted write
// Config   : RELOAD_ON_ANY_WRITE_EN - when defined, any write to $4000-$400F
//            flips its channel's toggle, not only register 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apu_register_writer
    import apu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] reg_bank,
    output logic [4:0]   channel_enable,
    output logic [3:0]   reg_change,
    output logic         write_strobe
);

    parse_state_t r_state;
    parse_state_t w_state_next;
    logic [4:0]   r_addr;
    logic [127:0] r_bank;
    logic [4:0]   r_enable;
    logic [3:0]   r_change;
    logic         r_strobe;

    logic         w_accept_addr;
    logic         w_do_write;
    logic         w_timer_clear;
    logic         w_timer_count;
    logic         w_expired;
    logic [3:0]   w_flip;

    apu_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timer_clear),
        .i_count   (w_timer_count),
        .o_expired (w_expired)
    );

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ADDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept_addr = 1'b0;
        w_do_write    = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_count = 1'b0;
        case (r_state)
            ST_ADDR: begin
                // Out-of-range bytes are dropped here so a desynchronised
                // stream realigns on the next legal address
                if (rx_valid && (rx_data <= ADDR_MAX)) begin
                    w_accept_addr = 1'b1;
                    w_timer_clear = 1'b1;
                    w_state_next  = ST_DATA;
                end
            end
            ST_DATA: begin
                // A byte on the expiry cycle is still taken as data
                if (rx_valid) begin
                    w_do_write   = 1'b1;
                    w_state_next = ST_ADDR;
                end else begin
                    w_timer_count = 1'b1;
                    if (w_expired) begin
                        w_state_next = ST_ADDR;
                    end
                end
            end
            default: begin
                w_state_next = ST_ADDR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Reload toggle decode
    // ------------------------------------------------------------------
    always_comb begin
        w_flip = '0;
        if (w_do_write) begin
            if (!r_addr[4]) begin
`ifdef RELOAD_ON_ANY_WRITE_EN
                w_flip[r_addr[3:2]] = 1'b1;
`else
                // Register 3 of a channel carries the length/reload trigger
                if (r_addr[1:0] == 2'b11) begin
                    w_flip[r_addr[3:2]] = 1'b1;
                end
`endif
            end else if (r_addr == ADDR_STATUS) begin
                // Only an enabled channel being switched off needs a reload
                for (int c = 0; c < NUM_CH; c++) begin
                    w_flip[c] = r_enable[c] & ~rx_data[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Address latch and register bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_bank   <= '0;
            r_enable <= '0;
            r_change <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_do_write;
            r_change <= r_change ^ w_flip;
            if (w_accept_addr) begin
                r_addr <= rx_data[4:0];
            end
            if (w_do_write) begin
                if (!r_addr[4]) begin
                    r_bank[{r_addr[3:0], 3'b000} +: 8] <= rx_data;
                end else if (r_addr == ADDR_STATUS) begin
                    r_enable <= rx_data[4:0];
                end
                // $4010-$4014, $4016, $4017 are accepted but have no storage
            end
        end
    end

    assign reg_bank       = r_bank;
    assign channel_enable = r_enable;
    assign reg_change     = r_change;
    assign write_strobe   = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_apu_register_writer.sv
// ============================================================================
// Module   : tb_apu_register_writer
// Purpose  : Self-checking bench for apu_register_writer. Directed byte
//            sequences push hand-computed register state into a queue; a
//            monitor pops one entry per write_strobe and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apu_register_writer;

    localparam int T = 1024;

    typedef struct packed {
        logic [127:0] bank;
        logic [4:0]   en;
        logic [3:0]   chg;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] reg_bank;
    logic [4:0]   channel_enable;
    logic [3:0]   reg_change;
    logic         write_strobe;

    int n_cmp;
    int n_bad;

    exp_t exp_q[$];
    logic [127:0] e_bank;
    logic [4:0]   e_en;
    logic [3:0]   e_chg;

    apu_register_writer #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .reg_bank       (reg_bank),
        .channel_enable (channel_enable),
        .reg_change     (reg_change),
        .write_strobe   (write_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Compare every output against the model while no write is in flight
    task automatic check_idle(input string name);
        check({name, ".bank"},   reg_bank,              e_bank);
        check({name, ".en"},     {123'd0, channel_enable}, {123'd0, e_en});
        check({name, ".chg"},    {124'd0, reg_change},     {124'd0, e_chg});
        check({name, ".strobe"}, {127'd0, write_strobe},   128'd0);
    endtask

    // Each call leaves time at 1 unit after the edge that sampled the byte
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.bank = e_bank;
        e.en   = e_en;
        e.chg  = e_chg;
        exp_q.push_back(e);
    endtask

    // Caller updates e_* by hand before calling; the pair is sent back to back
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        push_exp();
        send(a);
        send(d);
    endtask

    // Scoreboard monitor: one expectation per write_strobe cycle
    always @(negedge clk) begin
        if (rst_n && write_strobe) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got strobe=1 expected no write");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb.bank", reg_bank, e.bank);
                check("sb.en",   {123'd0, channel_enable}, {123'd0, e.en});
                check("sb.chg",  {124'd0, reg_change},     {124'd0, e.chg});
            end
        end
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        e_bank   = '0;
        e_en     = '0;
        e_chg    = '0;

        #12;
        check_idle("reset_init");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // $4003 <= 8A: square 1 reload
        e_bank[31:24] = 8'h8A;
        e_chg ^= 4'b0001;
        wr(8'h03, 8'h8A);
        idle(2);
        check_idle("t2");

        // $4004 <= 3F: no reload unless any-write mode
        e_bank[39:32] = 8'h3F;
`ifdef RELOAD_ON_ANY_WRITE_EN
        e_chg ^= 4'b0010;
`endif
        wr(8'h04, 8'h3F);
        idle(2);
        check_idle("t3");

        // $4015 <= 0F (from 0: no flips), then 0D (sq2 switched off)
        e_en = 5'h0F;
        wr(8'h15, 8'h0F);
        e_en = 5'h0D;
        e_chg ^= 4'b0010;
        wr(8'h15, 8'h0D);
        idle(2);
        check_idle("t4");

        // Junk address 1F discarded, then $4002 <= 55, all back to back
        e_bank[23:16] = 8'h55;
`ifdef RELOAD_ON_ANY_WRITE_EN
        e_chg ^= 4'b0001;
`endif
        push_exp();
        send(8'h1F);
        send(8'h02);
        send(8'h55);
        idle(2);
        check_idle("t5");

        // Register 3 of sq2, tri, noise; consecutive pairs with no gap
        e_bank[63:56] = 8'h11;
        e_chg ^= 4'b0010;
        wr(8'h07, 8'h11);
        e_bank[95:88] = 8'h22;
        e_chg ^= 4'b0100;
        wr(8'h0B, 8'h22);
        e_bank[127:120] = 8'h33;
        e_chg ^= 4'b1000;
        wr(8'h0F, 8'h33);
        idle(2);
        check_idle("reg3_all");

        // Unimplemented $4010 and $4017: strobe only
        wr(8'h10, 8'hFF);
        wr(8'h17, 8'hAA);
        idle(2);
        check_idle("unimpl");

        // $4015 <= 00 from 0D: sq1, tri, noise were on and flip; sq2 was off
        e_en = 5'h00;
        e_chg ^= 4'b1101;
        wr(8'h15, 8'h00);
        idle(2);
        check_idle("status_off");

        // Data arriving on the expiry cycle still wins
        e_bank[55:48] = 8'h66;
`ifdef RELOAD_ON_ANY_WRITE_EN
        e_chg ^= 4'b0010;
`endif
        push_exp();
        send(8'h06);
        idle(T - 1);
        send(8'h66);
        idle(2);
        check_idle("timeout_edge");

        // One more idle cycle: address dropped, 55 then seen as bad address
        send(8'h07);
        idle(T);
        send(8'h55);
        idle(3);
        check_idle("timeout");

        // Reset with an address pending
        send(8'h05);
        #2 rst_n = 1'b0;
        #1;
        e_bank = '0;
        e_en   = '0;
        e_chg  = '0;
        check_idle("reset_mid");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // 0A must be an address now, not data for $4005
        e_bank[87:80] = 8'h77;
`ifdef RELOAD_ON_ANY_WRITE_EN
        e_chg ^= 4'b0100;
`endif
        wr(8'h0A, 8'h77);
        idle(2);
        check_idle("post_reset");

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_strobe: got %0d unmatched writes expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
